// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter: synchronous clear, count enable, flag at WIDTH-1.
module piso_bit_counter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load side and
// stallable serial side; back-to-back words leave no idle bubble.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             terminal;
    logic             in_shift;
    logic             accept;
    logic             advance;

    assign in_shift  = (state == SHIFT);
    assign busy      = in_shift;
    assign ser_valid = in_shift;
    assign ser_last  = in_shift && terminal;
    assign ser_out   = in_shift && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

    // Reset gates ready so nothing is accepted while reset is held.
    assign load_ready = !reset && (!in_shift || (ser_last && ser_en));
    assign accept     = load_valid && load_ready;
    assign advance    = in_shift && ser_en && !terminal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en && terminal) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= load_data;
        end else if (advance) begin
            if (MSB_FIRST) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (advance),
        .terminal (terminal)
    );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        ser_en;

    logic lr0, so0, sv0, sl0, b0;
    logic lr1, so1, sv1, sl1, b1;

    int checks   = 0;
    int failures = 0;
    int nvalid;

    localparam logic [31:0] W1 = 32'h00085D1E;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr0),
        .load_data(load_data), .ser_en(ser_en), .ser_out(so0),
        .ser_valid(sv0), .ser_last(sl0), .busy(b0)
    );

    piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr1),
        .load_data(load_data), .ser_en(ser_en), .ser_out(so1),
        .ser_valid(sv1), .ser_last(sl1), .busy(b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, " ready_lsb"}, lr0, 1'b1);
        chk({tag, " ready_msb"}, lr1, 1'b1);
        chk({tag, " valid"}, {sv0, sv1}, 2'b00);
        chk({tag, " last"},  {sl0, sl1}, 2'b00);
        chk({tag, " out"},   {so0, so1}, 2'b00);
        chk({tag, " busy"},  {b0, b1},   2'b00);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " ready"}, {lr0, lr1}, 2'b00);
        chk({tag, " valid"}, {sv0, sv1}, 2'b00);
        chk({tag, " last"},  {sl0, sl1}, 2'b00);
        chk({tag, " out"},   {so0, so1}, 2'b00);
        chk({tag, " busy"},  {b0, b1},   2'b00);
    endtask

    task automatic bit_check(input string tag, input logic [31:0] w, input int i, input logic exp_ready);
        logic exp_last;
        exp_last = (i == 31);
        chk($sformatf("%s valid[%0d]", tag, i), {sv0, sv1}, 2'b11);
        chk($sformatf("%s busy[%0d]", tag, i), {b0, b1}, 2'b11);
        chk($sformatf("%s lsb_out[%0d]", tag, i), so0, w[i]);
        chk($sformatf("%s msb_out[%0d]", tag, i), so1, w[31-i]);
        chk($sformatf("%s last[%0d]", tag, i), {sl0, sl1}, {exp_last, exp_last});
        chk($sformatf("%s ready[%0d]", tag, i), {lr0, lr1}, {exp_ready, exp_ready});
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        ser_en     = 1'b1;
        #2;
        reset_check("in_reset");

        // Release reset and present a word in the same cycle
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        load_data = W1;
        #1;
        idle_check("post_reset");

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            bit_check("basic", W1, i, i == 31);
        end
        @(negedge clk);
        #1;
        idle_check("basic_end");

        // Back-to-back: all-ones, all-zeros, then 0x12345678 held while busy
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'hFFFFFFFF;
        #1;
        chk("b2b first ready", lr0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load_data = 32'h00000000;
            #1;
            bit_check("ones", 32'hFFFFFFFF, i, i == 31);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load_data = 32'h12345678;
            #1;
            bit_check("zeros", 32'h00000000, i, i == 31);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            bit_check("held", 32'h12345678, i, i == 31);
        end
        @(negedge clk);
        #1;
        idle_check("b2b_end");

        // Stall of 5 cycles on bit 3
        nvalid = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = W1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            bit_check("pre_stall", W1, i, 1'b0);
            if (sv0) nvalid++;
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            ser_en = 1'b0;
            #1;
            chk($sformatf("stall valid[%0d]", s), {sv0, sv1}, 2'b11);
            chk($sformatf("stall lsb_out[%0d]", s), so0, W1[3]);
            chk($sformatf("stall msb_out[%0d]", s), so1, W1[28]);
            chk($sformatf("stall ready[%0d]", s), {lr0, lr1}, 2'b00);
            chk($sformatf("stall last[%0d]", s), {sl0, sl1}, 2'b00);
            if (sv0) nvalid++;
        end
        for (int i = 3; i < 32; i++) begin
            @(negedge clk);
            ser_en = 1'b1;
            #1;
            bit_check("post_stall", W1, i, i == 31);
            if (sv0) nvalid++;
        end
        @(negedge clk);
        #1;
        if (sv0) nvalid++;
        chk("stall valid_cycles", nvalid, 37);
        idle_check("stall_end");

        // Reset in the middle of a word
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'hA5A5A5A5;
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            bit_check("abort", 32'hA5A5A5A5, i, 1'b0);
        end
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b1;
        #1;
        reset_check("mid_reset");
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        reset_check("mid_reset_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;
        idle_check("after_abort0");
        @(negedge clk);
        #1;
        idle_check("after_abort1");
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 32'h00000001;
        #1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            bit_check("one", 32'h00000001, i, i == 31);
        end
        @(negedge clk);
        #1;
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
